// File: rtl/rr_arb_pkg.sv
// Shared types and sizing for the 8-way round-robin arbiter.
package rr_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/decoder3to8_en.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module decoder3to8_en (
  input  logic [2:0] in,
  input  logic       enable,
  output logic [7:0] out
);

  always_comb begin
    out = 8'h00;
    if (enable) out[in] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters sharing one resource, with a registered
// grant index, a one-GAP-cycle break-before-make and optional hold-time preemption.
//
// state | meaning
// IDLE  | no grant; arbitrate when en=1 and any req is set
// GRANT | gnt_idx holds the resource; watch for release or hold timeout
// GAP   | one cycle with gnt low before arbitration resumes
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [7:0]   req,
  output logic [7:0]   gnt,
  output logic [2:0]   gnt_idx,
  output logic         gnt_valid,
  output logic         preempt
);

  localparam bit               PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = PREEMPT_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               preempt_q, preempt_d;
  logic [CNT_W-1:0]   hold_q, hold_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] holder_mask;
  logic               others_wait;

  // Search starts just after the last holder; offset 8 wraps back to last itself.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = last_q + IDX_W'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    holder_mask         = '0;
    holder_mask[idx_q]  = 1'b1;
    others_wait         = |(req & ~holder_mask);
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && win_found) begin
          idx_d   = win_idx;
          valid_d = 1'b1;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!(&hold_q)) hold_d = hold_q + 1'b1;
        // A holder dropping req wins over a simultaneous timeout: no preempt pulse.
        if (!req[idx_q]) begin
          valid_d = 1'b0;
          last_d  = idx_q;
          state_d = GAP;
        end else if (PREEMPT_EN && (hold_q == HOLD_LAST) && others_wait) begin
          valid_d   = 1'b0;
          last_d    = idx_q;
          preempt_d = 1'b1;
          state_d   = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 3'd7;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  decoder3to8_en u_gnt_dec (
    .in     (idx_q),
    .enable (valid_q),
    .out    (gnt)
  );

  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 with MAX_HOLD=4; outputs sampled 1ns after each rising edge.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_idx,
                         input logic e_valid, input logic e_pre);
    chk({tag, ".gnt"},       {24'h0, gnt},       {24'h0, e_gnt});
    chk({tag, ".gnt_idx"},   {29'h0, gnt_idx},   {29'h0, e_idx});
    chk({tag, ".gnt_valid"}, {31'h0, gnt_valid}, {31'h0, e_valid});
    chk({tag, ".preempt"},   {31'h0, preempt},   {31'h0, e_pre});
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    req   = 8'h00;
    #2 rst_n = 1'b0;
    #1 chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // single request, then 2-cycle gap; next grant to 3 proves last=2
    req = 8'h04; en = 1'b1;
    tick(); chk_out("single_grant", 8'h04, 3'd2, 1'b1, 1'b0);
    req = 8'h00;
    tick(); chk_out("single_gap1", 8'h00, 3'd2, 1'b0, 1'b0);
    req = 8'h0C;
    tick(); chk_out("single_gap2", 8'h00, 3'd2, 1'b0, 1'b0);
    tick(); chk_out("after_last2", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h00;
    tick(); tick();

    // round robin from reset priority: 0..7,0
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      logic [2:0] w;
      w = 3'(n % 8);
      tick(); chk_out("rr_grant", 8'h01 << w, w, 1'b1, 1'b0);
      tick(); tick();
      req[w] = 1'b0;
      tick(); chk_out("rr_gap1", 8'h00, w, 1'b0, 1'b0);
      req[w] = 1'b1;
      tick(); chk_out("rr_gap2", 8'h00, w, 1'b0, 1'b0);
    end
    req = 8'h00;
    tick();

    // wrap: last=6, req=81 -> 7, then 0
    req = 8'h40;
    tick(); chk_out("wrap_set6", 8'h40, 3'd6, 1'b1, 1'b0);
    req = 8'h00;
    tick(); tick();
    req = 8'h81;
    tick(); chk_out("wrap_grant7", 8'h80, 3'd7, 1'b1, 1'b0);
    req = 8'h01;
    tick(); chk_out("wrap_rel7", 8'h00, 3'd7, 1'b0, 1'b0);
    req = 8'h81;
    tick(); chk_out("wrap_idle", 8'h00, 3'd7, 1'b0, 1'b0);
    tick(); chk_out("wrap_grant0", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    tick(); tick();

    // preemption: 3 holds, 5 waits from cycle 1
    req = 8'h08;
    tick(); chk_out("pre_grant3", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h28;
    tick(); chk_out("pre_hold1", 8'h08, 3'd3, 1'b1, 1'b0);
    tick(); chk_out("pre_hold2", 8'h08, 3'd3, 1'b1, 1'b0);
    tick(); chk_out("pre_hold3", 8'h08, 3'd3, 1'b1, 1'b0);
    tick(); chk_out("pre_pulse", 8'h00, 3'd3, 1'b0, 1'b1);
    tick(); chk_out("pre_gap", 8'h00, 3'd3, 1'b0, 1'b0);
    tick(); chk_out("pre_grant5", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h08;
    tick(); chk_out("pre_rel5", 8'h00, 3'd5, 1'b0, 1'b0);
    tick(); chk_out("pre_idle", 8'h00, 3'd5, 1'b0, 1'b0);
    tick(); chk_out("pre_regrant3", 8'h08, 3'd3, 1'b1, 1'b0);
    for (int c = 0; c < 20; c++) begin
      tick(); chk_out("solo_hold", 8'h08, 3'd3, 1'b1, 1'b0);
    end
    req = 8'h00;
    tick(); tick();

    // holder drops on the timeout edge: normal release, no pulse
    req = 8'h08;
    tick(); chk_out("tie_grant3", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h28;
    tick(); tick(); tick();
    req = 8'h20;
    tick(); chk_out("tie_release", 8'h00, 3'd3, 1'b0, 1'b0);
    tick(); chk_out("tie_gap", 8'h00, 3'd3, 1'b0, 1'b0);
    tick(); chk_out("tie_grant5", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h00;
    tick(); tick();

    // en gating
    en = 1'b0; req = 8'h10;
    tick(); chk_out("en_off1", 8'h00, 3'd5, 1'b0, 1'b0);
    tick(); chk_out("en_off2", 8'h00, 3'd5, 1'b0, 1'b0);
    en = 1'b1;
    tick(); chk_out("en_grant4", 8'h10, 3'd4, 1'b1, 1'b0);
    en = 1'b0;
    tick(); chk_out("en_drop1", 8'h10, 3'd4, 1'b1, 1'b0);
    tick(); chk_out("en_drop2", 8'h10, 3'd4, 1'b1, 1'b0);
    tick(); chk_out("en_drop3", 8'h10, 3'd4, 1'b1, 1'b0);
    req = 8'h00;
    tick(); chk_out("en_release", 8'h00, 3'd4, 1'b0, 1'b0);
    tick();
    en = 1'b1;

    // async reset mid-grant
    req = 8'h40;
    tick(); chk_out("ar_grant6", 8'h40, 3'd6, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("ar_async", 8'h00, 3'd0, 1'b0, 1'b0);
    req = 8'h41;
    #2 rst_n = 1'b1;
    tick(); chk_out("ar_grant0", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
